psswrd_entry: RTL
=================

// Module: psswrd_entry
// PURPOSE
//   Keypad front end for the parking access controller (the FSM that raises
//   alarm_1/alarm_2 and drives open_gate/close_gate).
//   - Collects BCD digit strobes from the entry keypad into a password attempt.
//   - Drives the controller's try_psswrd / psswrd_atmpt inputs directly.
//   - Handles CLEAR, ENTER, over/under-length entry, idle timeout and abort.
// PARAMETERS
//   DIGITS       2     digits per attempt; psswrd_atmpt width = DIGITS*4
//   TIMEOUT_CYC  1000  idle cycles (no accepted key) before auto-clear
//   CNT_W        10    timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//   clk           in   1         system clock; all logic on rising edge
//   rst           in   1         synchronous reset, active-low
//   entry_en      in   1         entry allowed (tied to sensor_1: vehicle present)
//   key_valid     in   1         one-cycle key strobe
//   key_code      in   4         0x0-0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF unused
//   try_psswrd    out  1         one-cycle pulse: psswrd_atmpt is valid
//   psswrd_atmpt  out  DIGITS*4  submitted attempt, BCD, first digit in MS nibble
//   digit_cnt     out  2         digits currently buffered (0..DIGITS)
//   entry_err     out  1         one-cycle pulse: short ENTER or extra digit
// BEHAVIOUR
//   Reset (rst==0 at a clk edge):
//   - state=IDLE; buffer, counter, digit_cnt, psswrd_atmpt, try_psswrd and
//     entry_err all 0.
//   - rst overrides every other input, including mid-entry or in SUBMIT.
//   Key decode:
//   - A key is accepted only when key_valid=1 and entry_en=1.
//   - Codes 0xC-0xF are ignored entirely (no state change, timer not cleared).
//   States:
//   - IDLE: digit -> buffer={0..,d}, digit_cnt=1, go COLLECT.
//     CLEAR / ENTER -> no effect.
//   - COLLECT: digit -> buffer={buffer[W-5:0],d}, digit_cnt+1;
//     go FULL when digit_cnt reaches DIGITS.
//     ENTER -> entry_err=1 next cycle, clear buffer, go IDLE.
//     CLEAR -> clear buffer, go IDLE.
//   - FULL: digit -> ignored, buffer unchanged, entry_err=1 next cycle.
//     ENTER -> go SUBMIT, psswrd_atmpt<=buffer.
//     CLEAR -> clear buffer, go IDLE.
//   - SUBMIT: exactly one cycle with try_psswrd=1; buffer cleared, go IDLE.
//     Keys presented in this cycle are dropped.
//   Latency:
//   - ENTER sampled at edge N -> try_psswrd=1 and new psswrd_atmpt visible
//     after edge N+1.
//   - psswrd_atmpt holds its value until the next SUBMIT.
//   Timeout:
//   - In COLLECT/FULL the counter increments each cycle with no accepted key.
//   - Any accepted key resets the counter to 0.
//   - Count reaches TIMEOUT_CYC-1 -> clear buffer, go IDLE; no error pulse.
//   - Counter is held at 0 in IDLE and SUBMIT.
//   Abort:
//   - entry_en=0 in COLLECT/FULL -> clear buffer, go IDLE at the same edge.
//   - entry_en=0 in SUBMIT does not cancel the pending try_psswrd pulse.
//   Priority at a single edge: rst > entry_en abort > accepted key > timeout.
//   - A key arriving on the timeout edge is processed and restarts the timer.
//   Pulses:
//   - try_psswrd and entry_err are registered, never high more than one
//     cycle, and never high together.
// TESTING
//   1 rst=0 for 2 cycles with key strobes present -> all outputs 0, digit_cnt=0.
//   2 en=1, keys 3,7,ENTER -> try_psswrd high 1 cycle, psswrd_atmpt=8'h37.
//   3 keys 5,ENTER -> entry_err pulse, no try_psswrd, digit_cnt=0,
//     psswrd_atmpt stays 8'h37.
//   4 keys 1,2,9,ENTER -> entry_err pulse on 9; try_psswrd with 8'h12.
//   5 key 4, idle TIMEOUT_CYC cycles -> digit_cnt=0; then ENTER -> no pulse.
//     Repeat with a key 8 on the expiry edge -> digit_cnt=2.
//   6 keys 6,CLEAR,8,1,ENTER -> 8'h81; also keys 2 then en=0 -> digit_cnt=0
//     next cycle, no try_psswrd.

Source files
------------

// File: rtl/psswrd_entry.sv
// psswrd_entry -- keypad front end for the parking access controller.
//
// Collects BCD digit strobes from the entry keypad into a fixed-length
// password attempt and hands it to the gate controller as a one-cycle
// try_psswrd pulse together with psswrd_atmpt. CLEAR, ENTER, short or
// over-long entry, idle timeout and vehicle-gone abort are handled here, so
// the controller only ever sees complete attempts.
//
// Ports
//   clk           in   rising-edge system clock
//   rst           in   synchronous reset, active-low
//   entry_en      in   entry allowed (vehicle present at the entry sensor)
//   key_valid     in   one-cycle key strobe
//   key_code      in   0x0-0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF unused
//   try_psswrd    out  one-cycle pulse, psswrd_atmpt is valid
//   psswrd_atmpt  out  submitted attempt, first digit in the MS nibble
//   digit_cnt     out  digits currently buffered
//   entry_err     out  one-cycle pulse on short ENTER or extra digit
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | buffer empty, waiting for the first digit
// COLLECT | 1..DIGITS-1 digits buffered, idle timer running
// FULL    | DIGITS digits buffered, waiting for ENTER, idle timer running
// SUBMIT  | one cycle: present buffer to the controller, then clear

module psswrd_entry #(
  parameter int DIGITS      = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  entry_en,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic                  try_psswrd,
  output logic [DIGITS*4-1:0]   psswrd_atmpt,
  output logic [1:0]            digit_cnt,
  output logic                  entry_err
);

  localparam int               W        = DIGITS * 4;
  localparam logic [1:0]       FULL_CNT = 2'(DIGITS);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    SUBMIT  = 2'd3
  } state_t;

  state_t           state_q,        state_d;
  logic [W-1:0]     buf_q,          buf_d;
  logic [1:0]       digit_cnt_q,    digit_cnt_d;
  logic [CNT_W-1:0] tmr_q,          tmr_d;
  logic [W-1:0]     psswrd_atmpt_q, psswrd_atmpt_d;
  logic             try_psswrd_q,   try_psswrd_d;
  logic             entry_err_q,    entry_err_d;

  logic key_acc;
  logic is_digit;
  logic is_clear;

  // Codes 0xC-0xF never count as accepted keys, so they do not restart the timer.
  assign key_acc  = key_valid & entry_en & (key_code <= 4'hB);
  assign is_digit = key_code <= 4'h9;
  assign is_clear = key_code == 4'hA;

  always_comb begin
    state_d        = state_q;
    buf_d          = buf_q;
    digit_cnt_d    = digit_cnt_q;
    tmr_d          = '0;
    psswrd_atmpt_d = psswrd_atmpt_q;
    try_psswrd_d   = 1'b0;
    entry_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_acc && is_digit) begin
          buf_d       = W'(key_code);
          digit_cnt_d = 2'd1;
          state_d     = (FULL_CNT == 2'd1) ? FULL : COLLECT;
        end
      end

      COLLECT, FULL: begin
        if (!entry_en) begin
          buf_d       = '0;
          digit_cnt_d = '0;
          state_d     = IDLE;
        end else if (key_acc) begin
          if (is_digit) begin
            if (state_q == COLLECT) begin
              buf_d       = (buf_q << 4) | W'(key_code);
              digit_cnt_d = digit_cnt_q + 2'd1;
              if (digit_cnt_q + 2'd1 == FULL_CNT) state_d = FULL;
            end else begin
              entry_err_d = 1'b1;
            end
          end else if (is_clear) begin
            buf_d       = '0;
            digit_cnt_d = '0;
            state_d     = IDLE;
          end else if (state_q == FULL) begin
            state_d = SUBMIT;
          end else begin
            entry_err_d = 1'b1;
            buf_d       = '0;
            digit_cnt_d = '0;
            state_d     = IDLE;
          end
        end else if (tmr_q == TMO_LAST) begin
          buf_d       = '0;
          digit_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      SUBMIT: begin
        // Keys and entry_en are ignored here; the attempt always goes out.
        try_psswrd_d   = 1'b1;
        psswrd_atmpt_d = buf_q;
        buf_d          = '0;
        digit_cnt_d    = '0;
        state_d        = IDLE;
      end

      default: begin
        buf_d       = '0;
        digit_cnt_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      buf_q          <= '0;
      digit_cnt_q    <= '0;
      tmr_q          <= '0;
      psswrd_atmpt_q <= '0;
      try_psswrd_q   <= 1'b0;
      entry_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      buf_q          <= buf_d;
      digit_cnt_q    <= digit_cnt_d;
      tmr_q          <= tmr_d;
      psswrd_atmpt_q <= psswrd_atmpt_d;
      try_psswrd_q   <= try_psswrd_d;
      entry_err_q    <= entry_err_d;
    end
  end

  assign try_psswrd   = try_psswrd_q;
  assign psswrd_atmpt = psswrd_atmpt_q;
  assign digit_cnt    = digit_cnt_q;
  assign entry_err    = entry_err_q;

endmodule
